// File: rtl/module_i2s_master.sv
// module_i2s_master
//   I2S bus master / codec-side transceiver. Divides clk down to a bit
//   clock, generates word select, shifts stereo DAC samples out MSB first
//   and shifts stereo ADC samples in. Left-justified framing: the first bit
//   of each slot appears on the same bclk falling edge that moves lrclk.
//
// Parameters
//   SAMPLE_WIDTH : bits per channel slot (>= 2)
//   BCLK_DIV     : clk cycles per bclk half-period (>= 1)
//
// Ports
//   clk        in  system clock, all logic on rising edge
//   reset      in  synchronous, active-high
//   left_in    in  left DAC sample, latched at frame start
//   right_in   in  right DAC sample, latched at frame start
//   adcda      in  serial ADC data, sampled on bclk rise
//   bclk       out bit clock (registered)
//   lrclk      out word select, 0 = left slot, 1 = right slot (registered)
//   dacda      out serial DAC data, changes on bclk fall (registered)
//   left_out   out last complete left ADC word
//   right_out  out last complete right ADC word
//   dataready  out one-cycle pulse when left_out/right_out update
module module_i2s_master #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_DIV     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  input  logic                    adcda,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    dacda,
  output logic [SAMPLE_WIDTH-1:0] left_out,
  output logic [SAMPLE_WIDTH-1:0] right_out,
  output logic                    dataready
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SAMPLE_WIDTH - 1);

  typedef enum logic {
    START = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                  state;
  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [SAMPLE_WIDTH-1:0] tx_shift;
  logic [SAMPLE_WIDTH-1:0] rx_shift;
  logic [SAMPLE_WIDTH-1:0] right_buf;
  logic [SAMPLE_WIDTH-1:0] left_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= START;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      right_buf <= '0;
      left_hold <= '0;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      dacda     <= 1'b0;
      left_out  <= '0;
      right_out <= '0;
      dataready <= 1'b0;
    end else begin
      dataready <= 1'b0;
      case (state)
        START: begin
          tx_shift  <= left_in;
          right_buf <= right_in;
          dacda     <= left_in[SAMPLE_WIDTH-1];
          div_cnt   <= '0;
          state     <= RUN;
        end

        RUN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
            if (!bclk) begin
              // Rising event: sample mid-bit.
              rx_shift <= {rx_shift[SAMPLE_WIDTH-2:0], adcda};
            end else if (bit_cnt != BIT_LAST) begin
              // Falling event inside a slot: present the next bit.
              bit_cnt  <= bit_cnt + BIT_W'(1);
              tx_shift <= tx_shift << 1;
              dacda    <= tx_shift[SAMPLE_WIDTH-2];
            end else begin
              // Slot end: lrclk and the new slot's MSB move together
              // (left-justified, no one-bit delay).
              bit_cnt <= '0;
              lrclk   <= ~lrclk;
              if (!lrclk) begin
                left_hold <= rx_shift;
                tx_shift  <= right_buf;
                dacda     <= right_buf[SAMPLE_WIDTH-1];
              end else begin
                left_out  <= left_hold;
                right_out <= rx_shift;
                dataready <= 1'b1;
                tx_shift  <= left_in;
                right_buf <= right_in;
                dacda     <= left_in[SAMPLE_WIDTH-1];
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: state <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_module_i2s_master.sv
module tb_module_i2s_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] left_in, right_in;
  logic        adcda;
  logic        bclk, lrclk, dacda, dataready;
  logic [15:0] left_out, right_out;

  logic [7:0]  left_in2, right_in2;
  logic        adcda2;
  logic        bclk2, lrclk2, dacda2, dataready2;
  logic [7:0]  left_out2, right_out2;

  always #5 clk = ~clk;

  assign adcda  = dacda;
  assign adcda2 = dacda2;

  module_i2s_master #(.SAMPLE_WIDTH(16), .BCLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .left_in(left_in), .right_in(right_in),
    .adcda(adcda), .bclk(bclk), .lrclk(lrclk), .dacda(dacda),
    .left_out(left_out), .right_out(right_out), .dataready(dataready)
  );

  module_i2s_master #(.SAMPLE_WIDTH(8), .BCLK_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .left_in(left_in2), .right_in(right_in2),
    .adcda(adcda2), .bclk(bclk2), .lrclk(lrclk2), .dacda(dacda2),
    .left_out(left_out2), .right_out(right_out2), .dataready(dataready2)
  );

  int checks = 0;
  int failures = 0;
  int m = 0;          // edges since the START edge
  bit mon_en = 1'b0;

  typedef struct {
    int          m;
    logic        bclk;
    logic        lrclk;
    logic        dacda;
    logic        dr;
    logic [15:0] lo;
    logic [15:0] ro;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (m=%0d)", name, act, exp, m);
    end
  endtask

  // Advance one clock; optionally check that dacda/lrclk only move on bclk falls.
  task automatic tick();
    logic pb, pd, pl;
    pb = bclk; pd = dacda; pl = lrclk;
    @(posedge clk);
    #1;
    m++;
    if (mon_en) begin
      if (dacda !== pd) chk("dacda_edge_on_bclk_fall", {pb, bclk}, 2'b10);
      if (lrclk !== pl) chk("lrclk_edge_on_bclk_fall", {pb, bclk}, 2'b10);
    end
  endtask

  task automatic do_start();
    reset = 1'b0;
    tick();
    m = 0;
  endtask

  task automatic wait_dr(input bit sel2, input int bound, output int at);
    do tick(); while (!(sel2 ? dataready2 : dataready) && m < bound);
    at = (sel2 ? dataready2 : dataready) ? m : -1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bclk"},      bclk, 0);
    chk({tag, "_lrclk"},     lrclk, 0);
    chk({tag, "_dacda"},     dacda, 0);
    chk({tag, "_left_out"},  left_out, 0);
    chk({tag, "_right_out"}, right_out, 0);
    chk({tag, "_dataready"}, dataready, 0);
  endtask

  initial begin
    int at;

    // Clock shape / serial order with left=8001, right=0000 (looped back).
    tbl[0]  = '{1,   1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{3,   1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[2]  = '{4,   1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[3]  = '{7,   1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[4]  = '{8,   1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[5]  = '{12,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[6]  = '{119, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[7]  = '{120, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[8]  = '{127, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[9]  = '{128, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[10] = '{200, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[11] = '{255, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[12] = '{256, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8001, 16'h0000};
    tbl[13] = '{257, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8001, 16'h0000};
    tbl[14] = '{384, 1'b0, 1'b1, 1'b0, 1'b0, 16'h8001, 16'h0000};
    tbl[15] = '{512, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8001, 16'h0000};

    left_in  = 16'h8001;
    right_in = 16'h0000;
    left_in2  = 8'h5A;
    right_in2 = 8'hC3;

    reset = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");

    do_start();
    mon_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      while (m < tbl[i].m) tick();
      chk($sformatf("vec%0d_bclk", i),      bclk,      tbl[i].bclk);
      chk($sformatf("vec%0d_lrclk", i),     lrclk,     tbl[i].lrclk);
      chk($sformatf("vec%0d_dacda", i),     dacda,     tbl[i].dacda);
      chk($sformatf("vec%0d_dataready", i), dataready, tbl[i].dr);
      chk($sformatf("vec%0d_left_out", i),  left_out,  tbl[i].lo);
      chk($sformatf("vec%0d_right_out", i), right_out, tbl[i].ro);
    end
    mon_en = 1'b0;

    // Loopback A5C3 / 3C5A, first frame included; small instance alongside.
    reset = 1'b1;
    tick();
    left_in  = 16'hA5C3;
    right_in = 16'h3C5A;
    do_start();
    wait_dr(1'b1, 1000, at);
    chk("w8_dr_at", at, 64);
    chk("w8_left_out", left_out2, 8'h5A);
    chk("w8_right_out", right_out2, 8'hC3);
    wait_dr(1'b0, 1000, at);
    chk("loop1_dr_at", at, 256);
    chk("loop1_left_out", left_out, 16'hA5C3);
    chk("loop1_right_out", right_out, 16'h3C5A);
    wait_dr(1'b0, 1000, at);
    chk("loop2_dr_at", at, 512);
    chk("loop2_left_out", left_out, 16'hA5C3);
    chk("loop2_right_out", right_out, 16'h3C5A);

    // Mid-frame change of left_in.
    reset = 1'b1;
    tick();
    left_in  = 16'h1234;
    right_in = 16'h0F0F;
    do_start();
    while (m < 64) tick();
    left_in = 16'hFFFF;
    wait_dr(1'b0, 1000, at);
    chk("mid1_dr_at", at, 256);
    chk("mid1_left_out", left_out, 16'h1234);
    chk("mid1_right_out", right_out, 16'h0F0F);
    wait_dr(1'b0, 1000, at);
    chk("mid2_dr_at", at, 512);
    chk("mid2_left_out", left_out, 16'hFFFF);

    // Reset for 3 cycles in the right slot.
    reset = 1'b1;
    tick();
    left_in  = 16'hA5C3;
    right_in = 16'h3C5A;
    do_start();
    while (m < 200) tick();
    reset = 1'b1;
    tick();
    chk_all_zero("midrst");
    tick();
    chk("midrst_dr_2", dataready, 0);
    tick();
    chk("midrst_dr_3", dataready, 0);
    do_start();
    wait_dr(1'b0, 1000, at);
    chk("midrst_dr_at", at, 256);
    chk("midrst_left_out", left_out, 16'hA5C3);
    chk("midrst_right_out", right_out, 16'h3C5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
